// File: rtl/press_seq_gen_if.sv
// -----------------------------------------------------------------------------
// press_seq_gen_if
//   Control/status bundle between a press-sequence requester and the
//   press_seq_gen waveform generator.
//
//   Signals
//     start    requester -> generator  start request (sampled only when idle)
//     n_press  requester -> generator  number of presses to emit (0..15)
//     abort    requester -> generator  cancel the running sequence
//     S1       generator -> requester  generated press line (1 = pressed)
//     busy     generator -> requester  sequence in progress
//     done     generator -> requester  one-cycle pulse on normal completion
//     sent     generator -> requester  presses completed in current/last run
//
//   Modports
//     master   the side that requests sequences (bench, self-test controller)
//     slave    the generator itself
// -----------------------------------------------------------------------------
interface press_seq_gen_if;
    logic       start;
    logic [3:0] n_press;
    logic       abort;
    logic       S1;
    logic       busy;
    logic       done;
    logic [3:0] sent;

    modport master (
        output start,
        output n_press,
        output abort,
        input  S1,
        input  busy,
        input  done,
        input  sent
    );

    modport slave (
        input  start,
        input  n_press,
        input  abort,
        output S1,
        output busy,
        output done,
        output sent
    );
endinterface

// File: rtl/press_seq_gen.sv
// -----------------------------------------------------------------------------
// press_seq_gen
//   Emits a button-press waveform on S1 for a downstream press-sequence
//   detector. On an accepted start it drives N presses, each PRESS_CYC cycles
//   high, separated by GAP_CYC cycles low, followed by a GUARD_CYC-cycle low
//   guard and a one-cycle done pulse.
//
//   Ports
//     clk   in   rising-edge system clock
//     rst   in   asynchronous active-high reset
//     bus   slave modport of press_seq_gen_if (start, n_press, abort in;
//           S1, busy, done, sent out)
//
//   Parameters (all in clk cycles, each must be >= 1)
//     PRESS_CYC  high time of one press
//     GAP_CYC    low time between consecutive presses
//     GUARD_CYC  low time after the final press before done
// -----------------------------------------------------------------------------
module press_seq_gen #(
    parameter int unsigned PRESS_CYC = 50_000_000,
    parameter int unsigned GAP_CYC   = 25_000_000,
    parameter int unsigned GUARD_CYC = 300_000_000
) (
    input  logic           clk,
    input  logic           rst,
    press_seq_gen_if.slave bus
);

    // Terminal timer values: the timer counts 0..X_CYC-1 inside a state.
    localparam logic [31:0] PRESS_LAST = 32'(PRESS_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);
    localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        GUARD,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  count_q, count_d;   // latched press count
    logic [3:0]  sent_q,  sent_d;
    logic        s1_q,    s1_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [3:0]  sent_inc;

    assign sent_inc = sent_q + 4'd1;

    // Next-state logic. abort only has meaning in the three active states;
    // in IDLE a simultaneous start takes precedence simply because abort is
    // never looked at there.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sent_d  = sent_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sent_d = 4'd0;
                    if (bus.n_press != 4'd0) begin
                        count_d = bus.n_press;
                        state_d = PRESS;
                    end else begin
                        state_d = FIN;
                    end
                end
            end

            PRESS: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (timer_q == PRESS_LAST) begin
                    // The count is at most 15, so sent stops at 15 without wrapping.
                    sent_d  = sent_inc;
                    state_d = (sent_inc == count_q) ? GUARD : GAP;
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (timer_q == GAP_LAST) begin
                    state_d = PRESS;
                end
            end

            GUARD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (timer_q == GUARD_LAST) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer restarts from zero on every state change so each state's
        // dwell time is measured independently.
        timer_d = (state_d != state_q) ? 32'd0 : (timer_q + 32'd1);

        // Outputs are decoded from the next state and registered, so they
        // line up cycle-for-cycle with the state they describe.
        s1_d   = (state_d == PRESS);
        busy_d = (state_d == PRESS) || (state_d == GAP) || (state_d == GUARD);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= 32'd0;
            count_q <= 4'd0;
            sent_q  <= 4'd0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            s1_q    <= s1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.S1   = s1_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sent = sent_q;

    // Structural invariants of the output encoding.
    a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_q);
    a_s1_implies_busy: assert property (@(posedge clk) disable iff (rst) s1_q |-> busy_q);

endmodule

// File: tb/tb_press_seq_gen.sv
module tb_press_seq_gen;

    localparam int P  = 3;
    localparam int G  = 2;
    localparam int GD = 4;

    logic clk;
    logic rst;

    press_seq_gen_if bus();

    press_seq_gen #(
        .PRESS_CYC(P),
        .GAP_CYC  (G),
        .GUARD_CYC(GD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       s1;
        logic       busy;
        logic       done;
        logic [3:0] sent;
    } exp_t;

    typedef struct {
        int n;
        int abort_at;          // trace index after which abort is driven, -1 none
        int restart_at;        // trace index after which start is re-pulsed, -1 none
        int restart_n;
        bit abort_with_start;
        int exp_sent;
        int exp_dones;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic s1, input logic busy, input logic done, input int sent);
        exp_t e;
        e.s1   = s1;
        e.busy = busy;
        e.done = done;
        e.sent = 4'(sent);
        return e;
    endfunction

    function automatic exp_t observed();
        return mk(bus.S1, bus.busy, bus.done, int'(bus.sent));
    endfunction

    // Build the expected per-cycle trace from the waveform description and
    // push it to the scoreboard. Entry 0 is the cycle right after start is
    // sampled; a trailing idle entry confirms done lasts one cycle.
    task automatic push_seq(input int n, input int abort_at);
        exp_t full[$];
        if (n == 0) begin
            full.push_back(mk(1'b0, 1'b0, 1'b1, 0));
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c < P; c++) full.push_back(mk(1'b1, 1'b1, 1'b0, i));
                if (i < n - 1)
                    for (int c = 0; c < G; c++) full.push_back(mk(1'b0, 1'b1, 1'b0, i + 1));
            end
            for (int c = 0; c < GD; c++) full.push_back(mk(1'b0, 1'b1, 1'b0, n));
            full.push_back(mk(1'b0, 1'b0, 1'b1, n));
        end
        full.push_back(mk(1'b0, 1'b0, 1'b0, n));

        if (abort_at >= 0 && abort_at < full.size() && full[abort_at].busy) begin
            for (int j = 0; j <= abort_at; j++) sb.push_back(full[j]);
            sb.push_back(mk(1'b0, 1'b0, 1'b0, int'(full[abort_at].sent)));
        end else begin
            foreach (full[j]) sb.push_back(full[j]);
        end
    endtask

    // Pop and compare one scoreboard entry per cycle until empty.
    task automatic drain(input string tag, input int drop_at, input int abort_at,
                         input int restart_at, input int restart_n, output int dones);
        exp_t e;
        exp_t got;
        int   j;
        int   budget;
        j      = 0;
        dones  = 0;
        budget = 400;
        while (sb.size() > 0) begin
            @(negedge clk);
            got = observed();
            e   = sb.pop_front();
            check($sformatf("%s_cyc%0d", tag, j), 32'(got), 32'(e));
            if (got.done) dones++;
            bus.start = (j < drop_at);
            bus.abort = (j == abort_at);
            if (j == restart_at) begin
                bus.start   = 1'b1;
                bus.n_press = 4'(restart_n);
            end
            j++;
            budget--;
            if (budget == 0) begin
                check({tag, "_budget"}, 32'(sb.size()), 32'd0);
                sb.delete();
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    vec_t vecs[8];
    int   dones;
    exp_t snap;

    initial begin
        vecs[0] = '{n: 2,  abort_at: -1, restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 2,  exp_dones: 1};
        vecs[1] = '{n: 0,  abort_at: -1, restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 0,  exp_dones: 1};
        vecs[2] = '{n: 3,  abort_at: 4,  restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 1,  exp_dones: 0};
        vecs[3] = '{n: 1,  abort_at: -1, restart_at: 1,  restart_n: 5, abort_with_start: 1'b0, exp_sent: 1,  exp_dones: 1};
        vecs[4] = '{n: 15, abort_at: -1, restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 15, exp_dones: 1};
        vecs[5] = '{n: 2,  abort_at: 9,  restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 2,  exp_dones: 0};
        vecs[6] = '{n: 1,  abort_at: -1, restart_at: -1, restart_n: 0, abort_with_start: 1'b1, exp_sent: 1,  exp_dones: 1};
        vecs[7] = '{n: 0,  abort_at: 0,  restart_at: -1, restart_n: 0, abort_with_start: 1'b0, exp_sent: 0,  exp_dones: 1};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.n_press = 4'd0;
        bus.abort   = 1'b0;

        // Reset state, while reset is held and just after release.
        @(negedge clk);
        check("reset_hold", 32'(observed()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", 32'(observed()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));

        // Table-driven sequences.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start   = 1'b1;
            bus.n_press = 4'(vecs[i].n);
            bus.abort   = vecs[i].abort_with_start;
            push_seq(vecs[i].n, vecs[i].abort_at);
            drain($sformatf("v%0d", i), 0, vecs[i].abort_at, vecs[i].restart_at,
                  vecs[i].restart_n, dones);
            check($sformatf("v%0d_sent", i), 32'(bus.sent), 32'(vecs[i].exp_sent));
            check($sformatf("v%0d_dones", i), 32'(dones), 32'(vecs[i].exp_dones));
        end

        // Back-to-back: start held high restarts right after the idle cycle
        // that follows done. A's trace is 14 entries, B's first press is entry 14.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.n_press = 4'd2;
        push_seq(2, -1);
        push_seq(2, -1);
        drain("b2b", 15, -1, -1, 0, dones);
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_sent", 32'(bus.sent), 32'd2);

        // Asynchronous reset during the second press.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.n_press = 4'd3;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("rst_pre", 32'(observed()), 32'(mk(1'b1, 1'b1, 1'b0, 1)));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        snap = observed();
        check("rst_async", 32'(snap), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d", j), 32'(observed()), 32'(mk(1'b0, 1'b0, 1'b0, 0)));
        end

        // Normal operation resumes after reset.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.n_press = 4'd1;
        push_seq(1, -1);
        drain("post_rst", 0, -1, -1, 0, dones);
        check("post_rst_dones", 32'(dones), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
